// File: rtl/wb_pkg.sv
// Shared encodings for the writeback scheduler: result-mux selects, requester
// indices, FSM states and the age-counter width.
package wb_pkg;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  localparam int AGE_W = 4;

  // Enum values double as bit positions in the per-requester vectors.
  typedef enum logic [1:0] {REQ_LD = 2'd0, REQ_ALU = 2'd1, REQ_LNK = 2'd2} req_e;

  typedef enum logic {NORMAL = 1'b0, AGED = 1'b1} state_e;

  // One-hot of the lowest set bit, which gives ld > alu > lnk ordering.
  function automatic logic [2:0] first_one(input logic [2:0] v);
    logic [2:0] r;
    r = 3'b000;
    if (v[0])      r = 3'b001;
    else if (v[1]) r = 3'b010;
    else if (v[2]) r = 3'b100;
    return r;
  endfunction

endpackage

// File: rtl/wb_age_counter.sv
// Saturating starvation counter for one requester: counts lost cycles and
// flags both the current and the next value reaching the limit.
module wb_age_counter
  import wb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o,
  output logic next_at_max_o
);

  localparam logic [AGE_W-1:0] MAX_C = AGE_W'(MAX);

  logic [AGE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && cnt_q != MAX_C)
      cnt_d = cnt_q + AGE_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign at_max_o      = (cnt_q == MAX_C);
  assign next_at_max_o = (cnt_d == MAX_C);

endmodule

// File: rtl/writeback_scheduler.sv
// Arbitrates the single register-file write port between load return, ALU and
// link producers: loads first, ALU/link round-robin, starvation aging on top.
module writeback_scheduler
  import wb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int RD_W       = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [RD_W-1:0] alu_rd,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [RD_W-1:0] ld_rd,
  output logic            ld_ready,
  input  logic            lnk_valid,
  input  logic [RD_W-1:0] lnk_rd,
  output logic            lnk_ready,
  input  logic            flush,
  output logic [1:0]      ResultSrc,
  output logic            RegWrite,
  output logic [RD_W-1:0] Rd,
  output logic            aged_grant
);

  state_e     state_q, state_d;
  req_e       rr_q, rr_d;
  logic [2:0] valid, elig, cand, grant, at_max, next_at_max, flush_clr;

  assign valid     = {lnk_valid, alu_valid, ld_valid};
  assign flush_clr = {flush, flush, 1'b0};
  assign elig      = valid & ~flush_clr;
  assign cand      = elig & at_max;

  always_comb begin
    grant      = '0;
    aged_grant = 1'b0;
    if (!reset) begin
      if (state_q == AGED && |cand) begin
        aged_grant = 1'b1;
        grant      = first_one(cand);
      end else if (elig[REQ_LD]) begin
        grant[REQ_LD] = 1'b1;
      end else if (elig[REQ_ALU] && elig[REQ_LNK]) begin
        grant[rr_q] = 1'b1;
      end else begin
        grant = elig;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant[REQ_ALU])      rr_d = REQ_LNK;
    else if (grant[REQ_LNK]) rr_d = REQ_ALU;

    // An aged event lasts exactly one cycle so a load is held off at most once per event.
    state_d = NORMAL;
    if (state_q == NORMAL && |next_at_max) state_d = AGED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= NORMAL;
      rr_q    <= REQ_ALU;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_age
    wb_age_counter #(.MAX(STARVE_MAX)) u_age (
      .clk           (clk),
      .reset         (reset),
      .inc_i         (valid[i] & ~grant[i]),
      .clr_i         (~valid[i] | grant[i] | flush_clr[i]),
      .at_max_o      (at_max[i]),
      .next_at_max_o (next_at_max[i])
    );
  end

  always_comb begin
    ResultSrc = RESULT_ALU;
    Rd        = '0;
    if (grant[REQ_LD]) begin
      ResultSrc = RESULT_MEM;
      Rd        = ld_rd;
    end else if (grant[REQ_ALU]) begin
      ResultSrc = RESULT_ALU;
      Rd        = alu_rd;
    end else if (grant[REQ_LNK]) begin
      ResultSrc = RESULT_PC4;
      Rd        = lnk_rd;
    end
  end

  // Writes to x0 are still consumed (ready high) but never reach the register file.
  assign RegWrite  = |grant && (Rd != '0);
  assign ld_ready  = grant[REQ_LD];
  assign alu_ready = grant[REQ_ALU];
  assign lnk_ready = grant[REQ_LNK];

endmodule

// File: tb/tb_writeback_scheduler.sv
// Directed bench for writeback_scheduler: a cycle-by-cycle vector table plus
// hand-written reset sequences.
module tb_writeback_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid, ld_valid, lnk_valid, flush;
  logic [4:0] alu_rd, ld_rd, lnk_rd;
  logic       alu_ready, ld_ready, lnk_ready, RegWrite, aged_grant;
  logic [1:0] ResultSrc;
  logic [4:0] Rd;

  int checks   = 0;
  int failures = 0;

  writeback_scheduler #(.STARVE_MAX(4), .RD_W(5)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_ready  (alu_ready),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_ready   (ld_ready),
    .lnk_valid  (lnk_valid),
    .lnk_rd     (lnk_rd),
    .lnk_ready  (lnk_ready),
    .flush      (flush),
    .ResultSrc  (ResultSrc),
    .RegWrite   (RegWrite),
    .Rd         (Rd),
    .aged_grant (aged_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld_v;
    logic [4:0] ld_rd;
    logic       alu_v;
    logic [4:0] alu_rd;
    logic       lnk_v;
    logic [4:0] lnk_rd;
    logic       fl;
    logic [2:0] rdy;   // {ld, alu, lnk}
    logic [1:0] src;
    logic       rw;
    logic [4:0] rd;
    logic       aged;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ldv, input logic [4:0] ldr, input logic av, input logic [4:0] ar,
                     input logic kv, input logic [4:0] kr, input logic fl,
                     input logic [2:0] rdy, input logic [1:0] src, input logic rw,
                     input logic [4:0] rd, input logic aged);
    vec_t v;
    v.ld_v = ldv; v.ld_rd = ldr; v.alu_v = av; v.alu_rd = ar;
    v.lnk_v = kv; v.lnk_rd = kr; v.fl = fl;
    v.rdy = rdy; v.src = src; v.rw = rw; v.rd = rd; v.aged = aged;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ldv, input logic [4:0] ldr, input logic av, input logic [4:0] ar,
                       input logic kv, input logic [4:0] kr, input logic fl);
    ld_valid = ldv; ld_rd = ldr; alu_valid = av; alu_rd = ar;
    lnk_valid = kv; lnk_rd = kr; flush = fl;
  endtask

  task automatic check(input string name, input logic [11:0] exp);
    logic [11:0] got;
    got = {ld_ready, alu_ready, lnk_ready, ResultSrc, RegWrite, Rd, aged_grant};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got rdy=%b src=%b rw=%b rd=%0d aged=%b expected rdy=%b src=%b rw=%b rd=%0d aged=%b",
               name, got[11:9], got[8:7], got[6], got[5:1], got[0],
               exp[11:9], exp[8:7], exp[6], exp[5:1], exp[0]);
    end
  endtask

  initial begin
    // Idle and single-requester cases
    add(0,0, 0,0, 0,0, 0, 3'b000, 2'b00, 0, 0, 0);
    add(0,0, 1,5, 0,0, 0, 3'b010, 2'b00, 1, 5, 0);
    add(0,0, 0,0, 1,0, 0, 3'b001, 2'b10, 0, 0, 0);
    // ALU/link round-robin starting from ALU
    add(0,0, 1,3, 1,4, 0, 3'b010, 2'b00, 1, 3, 0);
    add(0,0, 1,3, 1,4, 0, 3'b001, 2'b10, 1, 4, 0);
    add(0,0, 1,3, 1,4, 0, 3'b010, 2'b00, 1, 3, 0);
    add(0,0, 0,0, 0,0, 0, 3'b000, 2'b00, 0, 0, 0);
    // Load hogs the port: four load wins, then aged ALU grant, then load again
    for (int i = 0; i < 4; i++) add(1,9, 1,3, 0,0, 0, 3'b100, 2'b01, 1, 9, 0);
    add(1,9, 1,3, 0,0, 0, 3'b010, 2'b00, 1, 3, 1);
    for (int i = 0; i < 3; i++) add(1,9, 1,3, 0,0, 0, 3'b100, 2'b01, 1, 9, 0);
    // ALU counter is at 3 here; flush clears it so aging restarts from zero
    add(1,9, 1,3, 0,0, 1, 3'b100, 2'b01, 1, 9, 0);
    for (int i = 0; i < 4; i++) add(1,9, 1,3, 0,0, 0, 3'b100, 2'b01, 1, 9, 0);
    add(1,9, 1,3, 0,0, 0, 3'b010, 2'b00, 1, 3, 1);
    add(0,0, 0,0, 0,0, 0, 3'b000, 2'b00, 0, 0, 0);
    // Flush cancels a lone link request, which is granted once flush drops
    add(0,0, 0,0, 1,6, 1, 3'b000, 2'b00, 0, 0, 0);
    add(0,0, 0,0, 1,6, 0, 3'b001, 2'b10, 1, 6, 0);
    // Age ALU to the limit, then flush during the aged cycle: load wins unaged
    for (int i = 0; i < 4; i++) add(1,9, 1,3, 0,0, 0, 3'b100, 2'b01, 1, 9, 0);
    add(1,9, 1,3, 0,0, 1, 3'b100, 2'b01, 1, 9, 0);
    add(1,9, 1,3, 0,0, 0, 3'b100, 2'b01, 1, 9, 0);
    add(0,0, 0,0, 0,0, 0, 3'b000, 2'b00, 0, 0, 0);
    // Load to x0, all three valid, then pointer still on ALU
    add(1,0, 0,0, 0,0, 0, 3'b100, 2'b01, 0, 0, 0);
    add(1,9, 1,3, 1,4, 0, 3'b100, 2'b01, 1, 9, 0);
    add(0,0, 1,3, 1,4, 0, 3'b010, 2'b00, 1, 3, 0);
    add(0,0, 0,0, 0,0, 0, 3'b000, 2'b00, 0, 0, 0);

    // Reset with every requester valid: nothing granted
    reset = 1'b1;
    drive(1,7, 1,5, 1,6, 0);
    repeat (2) @(posedge clk);
    #1;
    #3 check("reset_all_valid", 12'b000_00_0_00000_0);
    @(posedge clk);
    #1 reset = 1'b0;
    #3 check("release_ld_wins", {3'b100, 2'b01, 1'b1, 5'd7, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1 drive(vecs[i].ld_v, vecs[i].ld_rd, vecs[i].alu_v, vecs[i].alu_rd,
               vecs[i].lnk_v, vecs[i].lnk_rd, vecs[i].fl);
      #3 check($sformatf("vec%0d", i),
               {vecs[i].rdy, vecs[i].src, vecs[i].rw, vecs[i].rd, vecs[i].aged});
    end

    // Reset mid-transfer with the pointer on LNK: the pointer must return to ALU
    @(posedge clk);
    #1 begin
      reset = 1'b1;
      drive(0,0, 1,3, 1,4, 0);
    end
    #3 check("reset_mid_transfer", 12'b000_00_0_00000_0);
    @(posedge clk);
    #1 reset = 1'b0;
    #3 check("post_reset_rr_alu", {3'b010, 2'b00, 1'b1, 5'd3, 1'b0});

    @(posedge clk);
    #1 drive(0,0, 0,0, 0,0, 0);
    #3 check("final_idle", 12'b000_00_0_00000_0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
